// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared rv32i types and constants for the fetch path
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FAULT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // A fetch target is legal only on a 4-byte boundary
    function automatic logic is_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous fetch queue with flush
module fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  fetch_entry_t             wr_data,
    output fetch_entry_t             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    fetch_entry_t mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    // Flush overrides both sides; a push into a full queue is legal only when the head leaves
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    // The extra pointer MSB tells full from empty when the index bits match
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; flush simply collapses the read pointer onto the write pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Entry storage needs no reset: empty masks whatever the slots hold
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - fetch PC sequencer and fetch queue front end for rv32i decode
module imem_fetch_ctrl
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    input  logic            out_ready,
    output logic            fault,
    output logic [XLEN-1:0] fault_pc
);

    fetch_state_e              state;
    fetch_state_e              state_nx;
    logic [31:0]               fetch_pc;
    logic [31:0]               fetch_pc_nx;
    logic [31:0]               fault_pc_q;
    logic [31:0]               fault_pc_nx;

    logic                      fq_push;
    logic                      fq_pop;
    logic                      fq_flush;
    logic                      fq_full;
    logic                      fq_empty;
    logic [$clog2(FQ_DEPTH):0] fq_count;
    fetch_entry_t              fq_wdata;
    fetch_entry_t              fq_head;

    fetch_fifo #(
        .DEPTH   (FQ_DEPTH)
    ) u_fetch_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (fq_flush),
        .push    (fq_push),
        .pop     (fq_pop),
        .wr_data (fq_wdata),
        .rd_data (fq_head),
        .full    (fq_full),
        .empty   (fq_empty),
        .count   (fq_count)
    );

    assign fq_wdata  = '{pc: fetch_pc, instr: imem_instr};
    assign imem_addr = fetch_pc;
    assign out_valid = (fq_count != '0);
    assign out_pc    = fq_empty ? 32'h0 : fq_head.pc;
    assign out_instr = fq_empty ? INSTR_NOP : fq_head.instr;
    assign fault     = (state == S_FAULT);
    assign fault_pc  = fault_pc_q;

    // Next state, next PC and queue controls; a redirect outranks everything else. A redirect
    // seen in S_IDLE takes effect on the edge that leaves S_IDLE, which is where it is applied.
    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        fault_pc_nx = fault_pc_q;
        fq_push     = 1'b0;
        fq_flush    = 1'b0;
        fq_pop      = out_valid && out_ready;

        if (redirect_valid) begin
            fq_flush = 1'b1;
            fq_pop   = 1'b0;
            if (is_aligned(redirect_pc[1:0])) begin
                fetch_pc_nx = redirect_pc;
                state_nx    = S_FETCH;
            end else begin
                fault_pc_nx = redirect_pc;
                state_nx    = S_FAULT;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    state_nx = S_FETCH;
                end
                S_FETCH: begin
                    if (fetch_en && (!fq_full || fq_pop)) begin
                        fq_push     = 1'b1;
                        fetch_pc_nx = fetch_pc + 32'd4;
                    end
                end
                S_FAULT: begin
                    state_nx = S_FAULT;
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end
    end

    // State, PC and fault address registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            fetch_pc   <= RESET_PC;
            fault_pc_q <= 32'h0;
        end else begin
            state      <= state_nx;
            fetch_pc   <= fetch_pc_nx;
            fault_pc_q <= fault_pc_nx;
        end
    end

endmodule
